// File: rtl/dbg_bus_master_if.sv
// Host-link and shared-bus signals of the serial debug bus initiator.
interface dbg_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        hold;
    logic        bus_own;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        rw;
    logic        vma;
    logic        busy;
    logic        err;

    modport master (
        input  rx_data, rx_valid, tx_busy, DI,
        output tx_data, tx_start, hold, bus_own, AD, DO, rw, vma, busy, err
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, DI,
        input  tx_data, tx_start, hold, bus_own, AD, DO, rw, vma, busy, err
    );
endinterface

// File: rtl/dbg_bus_master.sv
// Serial debug bus initiator: parses P/W/R commands from the UART byte stream,
// freezes the CPU via hold and runs read/write cycles on the shared bus.
module dbg_bus_master #(
    parameter int unsigned HOLD_WAIT = 2,
    parameter int unsigned TIMEOUT   = 3000000
) (
    input logic              clk,
    input logic              b_reset,
    dbg_bus_master_if.master bus
);

    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned HwW  = (HOLD_WAIT > 1) ? $clog2(HOLD_WAIT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
    localparam logic [HwW-1:0]  HwLast  = HwW'(HOLD_WAIT - 1);

    typedef enum logic [3:0] {
        StIdle, StAddrH, StAddrL, StCount, StHoldReq, StWdata,
        StBusW, StBusR1, StBusR2, StTxWait, StRelease
    } state_e;

    state_e          state_q, state_d;
    logic            is_write_q, is_write_d;
    logic [15:0]     addr_q, addr_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            err_q, err_d;
    logic            ping_q, ping_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [HwW-1:0]  hw_q, hw_d;

    logic rx_expected;
    logic tmo_exp;
    logic tx_ok;

    // State register and datapath registers; reset aborts any command at once.
    always_ff @(posedge clk or negedge b_reset) begin
        if (!b_reset) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            ping_q     <= 1'b0;
            tmo_q      <= '0;
            hw_q       <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            err_q      <= err_d;
            ping_q     <= ping_d;
            tmo_q      <= tmo_d;
            hw_q       <= hw_d;
        end
    end

    // Command parser, bus sequencer, reply transmitter and error tracking.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        err_d      = err_q;
        ping_d     = ping_q;
        hw_d       = '0;
        tmo_d      = '0;

        rx_expected = (state_q == StIdle) || (state_q == StAddrH) || (state_q == StAddrL) ||
                      (state_q == StCount) || (state_q == StWdata);
        tmo_exp     = (tmo_q == TmoLast) && !bus.rx_valid;
        // tx_busy lags tx_start by a cycle, so never strobe two cycles in a row
        tx_ok       = !bus.tx_busy && !tx_start_q;

        // Ping reply is handled first so a fresh 'P' in the same cycle stays pending
        if (ping_q && tx_ok && (state_q != StTxWait)) begin
            tx_start_d = 1'b1;
            tx_data_d  = 8'h2E;
            ping_d     = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        8'h50: begin
                            err_d  = 1'b0;
                            ping_d = 1'b1;
                        end
                        8'h57: begin
                            is_write_d = 1'b1;
                            state_d    = StAddrH;
                        end
                        8'h52: begin
                            is_write_d = 1'b0;
                            state_d    = StAddrH;
                        end
                        default: ;
                    endcase
                end
            end
            StAddrH: begin
                if (bus.rx_valid) begin
                    addr_d[15:8] = bus.rx_data;
                    state_d      = StAddrL;
                end else if (tmo_exp) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StAddrL: begin
                if (bus.rx_valid) begin
                    addr_d[7:0] = bus.rx_data;
                    state_d     = StCount;
                end else if (tmo_exp) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StCount: begin
                if (bus.rx_valid) begin
                    // A count byte of zero stands for 256 transfers
                    cnt_d   = {(bus.rx_data == 8'h00), bus.rx_data};
                    state_d = StHoldReq;
                end else if (tmo_exp) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StHoldReq: begin
                hw_d = hw_q + HwW'(1);
                if (hw_q == HwLast) begin
                    state_d = is_write_q ? StWdata : StBusR1;
                end
            end
            StWdata: begin
                if (bus.rx_valid) begin
                    wdata_d = bus.rx_data;
                    state_d = StBusW;
                end else if (tmo_exp) begin
                    err_d   = 1'b1;
                    state_d = StRelease;
                end
            end
            StBusW: begin
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 9'd1;
                state_d = (cnt_q == 9'd1) ? StRelease : StWdata;
            end
            StBusR1: begin
                state_d = StBusR2;
            end
            StBusR2: begin
                // Two-cycle access covers the synchronous RAM/ROM read latency
                rdata_d = bus.DI;
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 9'd1;
                state_d = StTxWait;
            end
            StTxWait: begin
                if (tx_ok) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rdata_q;
                    state_d    = (cnt_q == 9'd0) ? StRelease : StBusR1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A byte arriving while the sequencer owns the bus is lost
        if (bus.rx_valid && !rx_expected) begin
            err_d = 1'b1;
        end

        // Inter-byte timer restarts on every received byte and on every state entry
        if ((state_d != state_q) || bus.rx_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    assign bus.hold     = (state_q == StHoldReq) || (state_q == StWdata) ||
                          (state_q == StBusW) || (state_q == StBusR1) ||
                          (state_q == StBusR2) || (state_q == StTxWait) ||
                          (state_q == StRelease);
    assign bus.bus_own  = (state_q == StWdata) || (state_q == StBusW) ||
                          (state_q == StBusR1) || (state_q == StBusR2) ||
                          (state_q == StTxWait);
    assign bus.vma      = (state_q == StBusW) || (state_q == StBusR1) || (state_q == StBusR2);
    assign bus.rw       = (state_q != StBusW);
    assign bus.AD       = addr_q;
    assign bus.DO       = wdata_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.err      = err_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Scoreboard bench for dbg_bus_master: stimulus pushes expected tx bytes and
// bus accesses into queues; a negedge monitor pops and compares them.
module tb_dbg_bus_master;

    localparam int unsigned HOLD_WAIT = 2;
    localparam int unsigned TIMEOUT   = 200;
    localparam int          GAP       = 8;
    localparam int          TX_LEN    = 4;

    logic clk = 1'b0;
    logic b_reset = 1'b0;

    dbg_bus_master_if bus_if();

    dbg_bus_master #(
        .HOLD_WAIT (HOLD_WAIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .b_reset (b_reset),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_tx [$];
    logic [15:0] exp_rd [$];
    logic [23:0] exp_wr [$];

    int tx_seen = 0;
    int rd_seen = 0;
    int wr_seen = 0;
    bit force_busy = 1'b0;
    int busy_cnt = 0;
    bit hold_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_data"},  32'(bus_if.tx_data),  32'h0);
        check({tag, "_tx_start"}, 32'(bus_if.tx_start), 32'h0);
        check({tag, "_hold"},     32'(bus_if.hold),     32'h0);
        check({tag, "_bus_own"},  32'(bus_if.bus_own),  32'h0);
        check({tag, "_AD"},       32'(bus_if.AD),       32'h0);
        check({tag, "_DO"},       32'(bus_if.DO),       32'h0);
        check({tag, "_rw"},       32'(bus_if.rw),       32'h1);
        check({tag, "_vma"},      32'(bus_if.vma),      32'h0);
        check({tag, "_busy"},     32'(bus_if.busy),     32'h0);
        check({tag, "_err"},      32'(bus_if.err),      32'h0);
    endtask

    // Synchronous RAM model: DI follows AD, writes land on BUS_W cycles
    initial begin
        bus_if.DI = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_if.vma && !bus_if.rw) mem[bus_if.AD] = bus_if.DO;
            bus_if.DI = mem[bus_if.AD];
        end
    end

    // UART transmitter model: busy for TX_LEN cycles after each start
    initial begin
        bus_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.tx_start) busy_cnt = TX_LEN;
            else if (busy_cnt > 0) busy_cnt--;
            bus_if.tx_busy = force_busy || (busy_cnt != 0);
        end
    end

    // Monitor: pops the scoreboard on tx strobes and bus cycles
    initial begin
        bit prev_hold, prev_own, rising;
        int hcnt, run;
        logic [15:0] ad_first;
        logic [23:0] w;
        logic [7:0] t;
        logic [15:0] r;
        prev_hold = 1'b0; prev_own = 1'b0; rising = 1'b0; hcnt = 0; run = 0; ad_first = '0;
        forever begin
            @(negedge clk);
            if (!b_reset) begin
                prev_hold = 1'b0; prev_own = 1'b0; rising = 1'b0; hcnt = 0; run = 0;
            end else begin
                if (bus_if.tx_start) begin
                    tx_seen++;
                    if (exp_tx.size() == 0) check("tx_extra", 32'h1, 32'h0);
                    else begin
                        t = exp_tx.pop_front();
                        check("tx_data", 32'(bus_if.tx_data), 32'(t));
                    end
                end
                if (bus_if.vma) check("vma_hold_own", {bus_if.hold, bus_if.bus_own}, 32'h3);
                if (bus_if.vma && !bus_if.rw) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) check("wr_extra", 32'h1, 32'h0);
                    else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 32'(bus_if.AD), 32'(w[23:8]));
                        check("wr_data", 32'(bus_if.DO), 32'(w[7:0]));
                    end
                end
                if (bus_if.vma && bus_if.rw) begin
                    if (run == 0) ad_first = bus_if.AD;
                    else check("rd_ad_stable", 32'(bus_if.AD), 32'(ad_first));
                    run++;
                end else if (run > 0) begin
                    rd_seen++;
                    check("rd_len", run, 32'd2);
                    if (exp_rd.size() == 0) check("rd_extra", 32'h1, 32'h0);
                    else begin
                        r = exp_rd.pop_front();
                        check("rd_addr", 32'(ad_first), 32'(r));
                    end
                    run = 0;
                end
                if (bus_if.hold && !prev_hold) begin
                    rising = 1'b1;
                    hcnt = 0;
                end
                if (rising && bus_if.hold && !bus_if.bus_own) hcnt++;
                if (bus_if.bus_own && !prev_own) begin
                    check("own_delay", hcnt, HOLD_WAIT);
                    rising = 1'b0;
                end
                if (!bus_if.bus_own && prev_own) check("own_drop_hold", 32'(bus_if.hold), 32'h1);
                if (!bus_if.hold && prev_hold) check("hold_drop_order", 32'(prev_own), 32'h0);
                if (bus_if.hold) hold_seen = 1'b1;
                prev_hold = bus_if.hold;
                prev_own  = bus_if.bus_own;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat (GAP) @(negedge clk);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        bit done;
        i = 0;
        done = 1'b0;
        while (i < budget && !done) begin
            @(negedge clk);
            done = !bus_if.busy && !bus_if.hold && (exp_tx.size() == 0) &&
                   (exp_rd.size() == 0) && (exp_wr.size() == 0);
            i++;
        end
        check({name, "_done"}, 32'(done), 32'h1);
    endtask

    task automatic wait_vma(input string name, input bit want_rw);
        int i;
        i = 0;
        while (i < 100 && !(bus_if.vma && (bus_if.rw == want_rw))) begin
            @(negedge clk);
            i++;
        end
        check({name, "_vma_seen"}, 32'(bus_if.vma && (bus_if.rw == want_rw)), 32'h1);
    endtask

    // Directed stimulus
    initial begin
        int rd0, tx0;
        logic [15:0] a;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            a = 16'(i);
            mem[i] = a[7:0] ^ a[15:8] ^ 8'h5A;
        end

        #1;
        check_reset_vals("rst");
        repeat (3) @(negedge clk);
        b_reset = 1'b1;

        // Timeout on a partial write command: err set, no bus write
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h20);
        repeat (TIMEOUT + 20) @(negedge clk);
        check("tmo_err", 32'(bus_if.err), 32'h1);
        check("tmo_busy", 32'(bus_if.busy), 32'h0);
        check("tmo_wr_count", wr_seen, 32'd0);

        // Ping clears err and replies 0x2E without touching hold
        hold_seen = 1'b0;
        exp_tx.push_back(8'h2E);
        send_byte(8'h50);
        wait_done("ping", 200);
        check("ping_err", 32'(bus_if.err), 32'h0);
        check("ping_hold", 32'(hold_seen), 32'h0);

        // Two-byte write
        exp_wr.push_back({16'h0010, 8'hAA});
        exp_wr.push_back({16'h0011, 8'h55});
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'h55);
        wait_done("write", 200);
        check("write_mem10", 32'(mem[16'h0010]), 32'hAA);
        check("write_mem11", 32'(mem[16'h0011]), 32'h55);
        check("write_err", 32'(bus_if.err), 32'h0);

        // Two-byte read with the transmitter stalled for 100 cycles
        rd0 = rd_seen;
        tx0 = tx_seen;
        force_busy = 1'b1;
        exp_rd.push_back(16'h0010); exp_rd.push_back(16'h0011);
        exp_tx.push_back(8'hAA);    exp_tx.push_back(8'h55);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
        repeat (100) @(negedge clk);
        check("stall_reads", rd_seen - rd0, 32'd1);
        check("stall_tx", tx_seen - tx0, 32'd0);
        force_busy = 1'b0;
        wait_done("read", 300);
        check("read_tx_count", tx_seen - tx0, 32'd2);

        // Byte injected during BUS_R2 is dropped; read still completes
        mem[16'h0030] = 8'h3C;
        exp_rd.push_back(16'h0030);
        exp_tx.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h30); send_byte(8'h01);
        wait_vma("drop", 1'b1);
        @(negedge clk);
        bus_if.rx_data  = 8'h99;
        bus_if.rx_valid = 1'b1;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        wait_done("drop", 200);
        check("drop_err", 32'(bus_if.err), 32'h1);

        // 256-byte read wrapping through 0xFFFF
        rd0 = rd_seen;
        tx0 = tx_seen;
        for (int k = 0; k < 256; k++) begin
            a = 16'hFFFF + 16'(k);
            exp_rd.push_back(a);
            exp_tx.push_back(mem[a]);
        end
        send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
        wait_done("wrap", 256 * 20);
        check("wrap_reads", rd_seen - rd0, 32'd256);
        check("wrap_tx", tx_seen - tx0, 32'd256);

        // Reset asserted during BUS_W
        exp_wr.push_back({16'h0100, 8'h11});
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11);
        wait_vma("rstw", 1'b0);
        #1;
        b_reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        b_reset = 1'b1;
        check("midrst_mem", 32'(mem[16'h0100]), 32'h11);
        exp_tx.push_back(8'h2E);
        send_byte(8'h50);
        wait_done("ping2", 200);
        check("ping2_err", 32'(bus_if.err), 32'h0);
        repeat (20) @(negedge clk);
        check("midrst_no_more_wr", 32'(mem[16'h0101]), 32'(8'h01 ^ 8'h01 ^ 8'h5A));

        check("q_tx_empty", exp_tx.size(), 32'd0);
        check("q_rd_empty", exp_rd.size(), 32'd0);
        check("q_wr_empty", exp_wr.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
